// File: rtl/fft_stream_ctrl.sv
// Streaming controller for a pipelined radix-2 FFT: handshake, pipeline enable, commutator selects and output bin tagging.
// Optional tail flush (zero injection until the pipeline drains) is enabled by defining FFT_CTRL_FLUSH_EN.
module fft_stream_ctrl #(
  parameter int N       = 8,
  parameter int LATENCY = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   out_ready,
  output logic                   fft_en,
  output logic                   zero_inj,
  output logic [$clog2(N)-2:0]   dc_sel,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [$clog2(N)-1:0]   out_idx,
  output logic                   frame_err
);

  localparam int W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN
`ifdef FFT_CTRL_FLUSH_EN
    , FLUSH
`endif
  } state_t;

  state_t               state;
  logic [W-1:0]         in_cnt;
  logic [W-1:0]         out_cnt;
  logic [W-1:0]         out_cnt_rev;
  logic [LATENCY-1:0]   vsr;
  logic                 err_q;
  logic                 in_flush;
  logic                 accept;
  logic                 advance;
  logic                 sr_empty;

`ifdef FFT_CTRL_FLUSH_EN
  assign in_flush = (state == FLUSH);
`else
  assign in_flush = 1'b0;
`endif

  // Every externally visible output is qualified with reset so nothing leaks
  // out during a reset cycle, even before the registers have been cleared.
  assign in_ready = reset && out_ready && !in_flush;
  assign accept   = in_valid && in_ready;
  assign advance  = reset && (accept || (in_flush && out_ready));
  assign fft_en   = advance;
  assign zero_inj = reset && in_flush;
  assign sr_empty = ~|vsr;

  assign out_valid = reset && vsr[LATENCY-1];
  assign out_last  = out_valid && (out_cnt == W'(N-1));
  assign out_idx   = reset ? out_cnt_rev : '0;
  assign frame_err = reset && err_q;

  always_comb begin
    out_cnt_rev = '0;
    for (int b = 0; b < W; b++) out_cnt_rev[b] = out_cnt[W-1-b];
  end

  // Stage s+2 switches every N/2^(s+2) samples, i.e. follows in_cnt bit W-2-s.
  always_comb begin
    dc_sel = '0;
    for (int s = 0; s < W-1; s++) dc_sel[s] = reset && in_cnt[W-2-s];
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      vsr     <= '0;
      err_q   <= 1'b0;
    end else begin
      if (advance) begin
        in_cnt <= in_cnt + W'(1);
        vsr    <= {vsr[LATENCY-2:0], accept};
        if (vsr[LATENCY-1] && out_ready) out_cnt <= out_cnt + W'(1);
      end

      // Counters deliberately do not resync on a bad in_last; the flag is sticky.
      if (accept && (in_last != (in_cnt == W'(N-1)))) err_q <= 1'b1;

      case (state)
        IDLE: if (accept) state <= RUN;
        RUN: begin
          if (in_cnt == '0 && !in_valid) begin
            if (sr_empty) state <= IDLE;
`ifdef FFT_CTRL_FLUSH_EN
            else          state <= FLUSH;
`endif
          end
        end
`ifdef FFT_CTRL_FLUSH_EN
        FLUSH: if (sr_empty) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Directed self-checking bench for fft_stream_ctrl (N=8, LATENCY=10); follows FFT_CTRL_FLUSH_EN like the RTL.
module tb_fft_stream_ctrl;

  localparam int N   = 8;
  localparam int LAT = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, fft_en, zero_inj, out_valid, out_last, frame_err;
  logic [1:0] dc_sel;
  logic [2:0] out_idx;

  int n_cmp = 0;
  int n_bad = 0;

  // Natural-order bin of the k-th result of a frame.
  logic [2:0] br [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

  fft_stream_ctrl #(.N(N), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .fft_en    (fft_en),
    .zero_inj  (zero_inj),
    .dc_sel    (dc_sel),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic r);
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    tick();
    reset = 1'b1;
    #1;
  endtask

  // One accepted sample; c counts enabled edges since reset (all edges are accepts here).
  task automatic stream_accept(input int c);
    logic [2:0] cc = 3'(c % 8);
    int         s  = c - LAT;
    logic [4:0] exp_ctl;
    logic [4:0] exp_out;
    drive(1'b1, cc == 3'd7, 1'b1);
    exp_ctl = {3'b110, cc[0], cc[1]};
    exp_out = (s >= 0) ? {1'b1, (s % 8) == 7, br[s % 8]} : 5'b0;
    n_cmp++;
    if ({in_ready, fft_en, zero_inj, dc_sel} !== exp_ctl) begin
      n_bad++;
      $display("FAIL stream_ctl c=%0d: got %b want %b", c, {in_ready, fft_en, zero_inj, dc_sel}, exp_ctl);
    end
    n_cmp++;
    if ({out_valid, out_last, out_idx} !== exp_out) begin
      n_bad++;
      $display("FAIL stream_out c=%0d: got %b want %b", c, {out_valid, out_last, out_idx}, exp_out);
    end
    tick();
  endtask

`ifdef FFT_CTRL_FLUSH_EN
  // After k accepts: one bubble cycle in RUN, 11 FLUSH cycles, then IDLE.
  task automatic flush_tail(input int k);
    for (int t = k; t <= k + 12; t++) begin
      int         s   = (t == k) ? k - LAT : t - 11;
      logic       zi  = (t >= k + 1) && (t <= k + 11);
      logic [2:0] cc  = 3'(((t == k) ? k : t - 1) % 8);
      logic [4:0] exp_ctl;
      logic [4:0] exp_out;
      drive(1'b0, 1'b0, 1'b1);
      exp_ctl = {!zi, zi, zi, cc[0], cc[1]};
      exp_out = (s >= 0 && s <= k - 1) ? {1'b1, (s % 8) == 7, br[s % 8]} : 5'b0;
      n_cmp++;
      if ({in_ready, fft_en, zero_inj, dc_sel} !== exp_ctl) begin
        n_bad++;
        $display("FAIL flush_ctl t=%0d: got %b want %b", t, {in_ready, fft_en, zero_inj, dc_sel}, exp_ctl);
      end
      n_cmp++;
      if ({out_valid, out_last, out_idx} !== exp_out) begin
        n_bad++;
        $display("FAIL flush_out t=%0d: got %b want %b", t, {out_valid, out_last, out_idx}, exp_out);
      end
      tick();
    end
  endtask
`else
  // No input for n cycles after k enabled edges: the pipeline must freeze in place.
  task automatic idle_hold(input int k, input int n);
    logic [2:0] cc = 3'(k % 8);
    int         s  = k - LAT;
    logic [4:0] exp_ctl;
    logic [4:0] exp_out;
    exp_ctl = {3'b100, cc[0], cc[1]};
    exp_out = (s >= 0) ? {1'b1, (s % 8) == 7, br[s % 8]} : 5'b0;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({in_ready, fft_en, zero_inj, dc_sel} !== exp_ctl) begin
        n_bad++;
        $display("FAIL idle_ctl i=%0d: got %b want %b", i, {in_ready, fft_en, zero_inj, dc_sel}, exp_ctl);
      end
      n_cmp++;
      if ({out_valid, out_last, out_idx} !== exp_out) begin
        n_bad++;
        $display("FAIL idle_out i=%0d: got %b want %b", i, {out_valid, out_last, out_idx}, exp_out);
      end
      tick();
    end
  endtask
`endif

  task automatic test_reset;
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({in_ready, fft_en, zero_inj, out_valid, out_last, frame_err, dc_sel, out_idx} !== 11'b0) begin
        n_bad++;
        $display("FAIL reset_hold: got %b want %b",
                 {in_ready, fft_en, zero_inj, out_valid, out_last, frame_err, dc_sel, out_idx}, 11'b0);
      end
    end
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({in_ready, fft_en, zero_inj, out_valid, out_last, frame_err, dc_sel, out_idx} !== 11'b100_0000_0000) begin
      n_bad++;
      $display("FAIL reset_idle: got %b want %b",
               {in_ready, fft_en, zero_inj, out_valid, out_last, frame_err, dc_sel, out_idx}, 11'b100_0000_0000);
    end
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({in_ready, fft_en} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_noready: got %b want %b", {in_ready, fft_en}, 2'b00);
    end
    drive(1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_single_frame;
    apply_reset();
    for (int c = 0; c < 8; c++) stream_accept(c);
`ifdef FFT_CTRL_FLUSH_EN
    flush_tail(8);
`else
    idle_hold(8, 12);
    for (int c = 8; c < 18; c++) stream_accept(c);
`endif
  endtask

  task automatic test_back_to_back;
    apply_reset();
`ifdef FFT_CTRL_FLUSH_EN
    for (int c = 0; c < 16; c++) stream_accept(c);
    flush_tail(16);
`else
    for (int c = 0; c < 24; c++) stream_accept(c);
    idle_hold(24, 5);
`endif
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_frame_err: got %b want %b", frame_err, 1'b0);
    end
  endtask

  task automatic test_stall;
    apply_reset();
    for (int c = 0; c < 12; c++) stream_accept(c);
    // Enabled edges stay at 12: result 2 (bin 2) sits at the output.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({in_ready, fft_en, zero_inj, dc_sel} !== 5'b00000) begin
        n_bad++;
        $display("FAIL stall_ctl i=%0d: got %b want %b", i, {in_ready, fft_en, zero_inj, dc_sel}, 5'b00000);
      end
      n_cmp++;
      if ({out_valid, out_last, out_idx} !== {2'b10, br[2]}) begin
        n_bad++;
        $display("FAIL stall_out i=%0d: got %b want %b", i, {out_valid, out_last, out_idx}, {2'b10, br[2]});
      end
      tick();
    end
    for (int c = 12; c < 16; c++) stream_accept(c);
  endtask

  task automatic test_frame_err;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, c == 4, 1'b1);
      n_cmp++;
      if (frame_err !== (c >= 5)) begin
        n_bad++;
        $display("FAIL frame_err c=%0d: got %b want %b", c, frame_err, c >= 5);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (frame_err !== 1'b1) begin
        n_bad++;
        $display("FAIL frame_err_sticky i=%0d: got %b want %b", i, frame_err, 1'b1);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, c == 0, 1'b1);
      if (c == 3) begin
        n_cmp++;
        if (frame_err !== 1'b1) begin
          n_bad++;
          $display("FAIL mid_pre_err: got %b want %b", frame_err, 1'b1);
        end
      end
      tick();
    end
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({in_ready, fft_en, zero_inj, out_valid, out_last, frame_err, dc_sel, out_idx} !== 11'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got %b want %b",
               {in_ready, fft_en, zero_inj, out_valid, out_last, frame_err, dc_sel, out_idx}, 11'b0);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({fft_en, zero_inj, out_valid, frame_err} !== 4'b0000) begin
        n_bad++;
        $display("FAIL post_reset i=%0d: got %b want %b", i, {fft_en, zero_inj, out_valid, frame_err}, 4'b0000);
      end
      tick();
    end
    // A fresh stream must see neither stale samples nor a stale count.
    for (int c = 0; c < 12; c++) stream_accept(c);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_frame_err();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_stream_ctrl.md
FFT_STREAM_CTRL -- requirements
Module: fft_stream_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, FFT points (power of 2, >=4).
REQ-002 SHALL have parameter LATENCY, default 10, number of enabled cycles from a sample entering the FFT pipeline to its result leaving it.
REQ-003 SHALL have port clk  input  1  sole clock; all logic rises on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; 0 resets on the next posedge.
REQ-005 SHALL have port in_valid  input  1  upstream sample valid.
REQ-006 SHALL have port in_last  input  1  upstream marks the last sample of the frame.
REQ-007 SHALL have port in_ready  output  1  controller accepts a sample this cycle.
REQ-008 SHALL have port out_ready  input  1  downstream accepts an FFT result.
REQ-009 SHALL have port fft_en  output  1  advance enable for every FFT pipeline register.
REQ-010 SHALL have port zero_inj  output  1  FFT input mux selects 0+0j instead of the upstream sample.
REQ-011 SHALL have port dc_sel  output  $clog2(N)-1  commutator switch per stage; bit s is for stage s+2.
REQ-012 SHALL have port out_valid  output  1  FFT output holds a valid result.
REQ-013 SHALL have port out_last  output  1  result is bin N-1 of its frame.
REQ-014 SHALL have port out_idx  output  $clog2(N)  natural-order frequency bin of the current result.
REQ-015 SHALL have port frame_err  output  1  sticky error: in_last disagreed with the sample count.

Function
REQ-016 SHALL use states IDLE, RUN and FLUSH; reset enters IDLE.
REQ-017 SHALL assert in_ready = out_ready AND state != FLUSH.
REQ-018 SHALL define accept = in_valid AND in_ready; accept in IDLE moves to RUN.
REQ-019 SHALL drive fft_en = accept OR (state == FLUSH AND out_ready); the pipeline never advances without out_ready.
REQ-020 SHALL drive zero_inj = 1 only while in FLUSH.
REQ-021 SHALL keep a sample counter in_cnt of 0..N-1 that increments on each fft_en and wraps N-1 -> 0.
REQ-022 SHALL drive dc_sel bit s = in_cnt bit ($clog2(N)-2-s), so stage s+2 toggles every N/2^(s+2) enabled cycles.
REQ-023 SHALL keep a LATENCY-deep valid shift register that shifts only on fft_en; its input is accept (a zero-injected sample is tagged invalid).
REQ-024 SHALL assert out_valid when the shift-register tail is 1; it holds while fft_en = 0.
REQ-025 SHALL keep an output counter out_cnt of 0..N-1 that advances on out_valid AND out_ready AND fft_en, wrapping.
REQ-026 SHALL drive out_idx = bit-reverse(out_cnt) and out_last = (out_cnt == N-1) AND out_valid.
REQ-027 SHALL set frame_err when accept occurs with in_last != (in_cnt == N-1); frame_err clears only on reset and the counters do not resync.
REQ-028 SHALL move RUN -> IDLE when in_cnt == 0, in_valid == 0 and the shift register is all zero.
REQ-029 SHALL NOT start a new frame mid-frame: in_cnt returns to 0 only by wrap.

Reset
REQ-030 SHALL, while reset == 0 at posedge, clear state to IDLE, in_cnt, out_cnt, the shift register and frame_err.
REQ-031 SHALL force in_ready, fft_en, zero_inj, out_valid, out_last and frame_err to 0, and dc_sel and out_idx to 0, during any cycle in which reset == 0.
REQ-032 SHALL discard in-flight samples on a reset asserted mid-operation; after release, no stale out_valid is produced.

Configuration
REQ-033 SHALL honour macro FFT_CTRL_FLUSH_EN. When it is defined: RUN -> FLUSH happens when in_cnt == 0, in_valid == 0 and the shift register is nonzero. In FLUSH, zeros are injected until the shift register empties, then the state goes to IDLE. When it is not defined: there is no FLUSH state, zero_inj is tied 0, and results stay in the pipeline until more input arrives.

Verification
REQ-034 SHALL cover N=8, LATENCY=10, out_ready=1: one frame of 8 accepted samples with in_last on the 8th. With FLUSH_EN, out_valid asserts for 8 cycles, first 10 enabled cycles after the first accept; out_idx = 0,4,2,6,1,5,3,7; out_last is on the 8th.
REQ-035 SHALL cover two back-to-back frames (16 samples): 16 consecutive out_valid cycles, out_last on result 8 and result 16, and dc_sel[0] toggling every 2 enabled cycles.
REQ-036 SHALL cover out_ready = 0 for 5 cycles mid-stream: in_ready = 0 and fft_en = 0 throughout; out_valid and out_idx hold; nothing is lost or duplicated.
REQ-037 SHALL cover in_last on the 5th sample: frame_err = 1 from the next cycle and stays 1 until reset.
REQ-038 SHALL cover reset = 0 for one cycle after 4 accepts: all outputs 0, and no out_valid for the next 20 cycles with no input.
REQ-039 SHALL cover FLUSH_EN undefined, one frame then idle input: out_valid stays 0 after the stall. When the next frame starts, out_valid appears, and the first-frame results emerge in order.
